// File: rtl/ula_ctrl.sv
// ula_ctrl: instruction sequencer for the 4-bit ALU datapath.
// Holds operand registers X/Y and a compare flag. It accepts one instruction
// at a time, keeps the ALU inputs stable for a settle window, and writes the
// result back to X or the status back to the flag. The OUT instruction emits X
// over a valid/ready port.
// Optional feature: define ULA_CTRL_RETIRE_CNT_EN to build the saturating
// retired-instruction counter. When it is undefined, retired is tied to 0.
module ula_ctrl #(
    parameter int DATA_W     = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_status,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              flag,
    output logic              busy,
    output logic [7:0]        retired
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_OUT} state_t;

    localparam logic [1:0] C_LDX = 2'b00;
    localparam logic [1:0] C_LDY = 2'b01;
    localparam logic [1:0] C_ALU = 2'b10;
    // Last EXEC cycle index before the ALU result is trusted.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t            state_q;
    logic [DATA_W-1:0] x_q, y_q, out_data_q;
    logic [7:0]        ir_q;
    logic [3:0]        cnt_q;
    logic              flag_q, out_valid_q;
    logic              is_cmp;
    logic              unused_ir;

    // Compare ops (eq/gt/lt) update the flag. Every other op writes X.
    assign is_cmp    = (ir_q[2:0] == 3'b011) || (ir_q[2:0] == 3'b100) || (ir_q[2:0] == 3'b101);
    // ir[5:4] carry no meaning for any instruction class.
    assign unused_ir = ^ir_q[5:4];

    assign instr_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign alu_x       = x_q;
    assign alu_y       = y_q;
    assign alu_op      = ir_q[2:0];
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign flag        = flag_q;

    // Sequencer FSM together with its operand, flag and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            ir_q        <= '0;
            cnt_q       <= '0;
            flag_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        ir_q    <= instr;
                        cnt_q   <= '0;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (ir_q[7:6])
                        C_LDX: begin
                            x_q     <= DATA_W'(ir_q[3:0]);
                            state_q <= S_IDLE;
                        end
                        C_LDY: begin
                            y_q     <= DATA_W'(ir_q[3:0]);
                            state_q <= S_IDLE;
                        end
                        C_ALU: begin
                            if (cnt_q == SETTLE_LAST) state_q <= S_WB;
                            else                      cnt_q   <= cnt_q + 4'd1;
                        end
                        default: begin
                            out_data_q  <= x_q;
                            out_valid_q <= 1'b1;
                            state_q     <= S_OUT;
                        end
                    endcase
                end
                S_WB: begin
                    if (is_cmp) flag_q <= alu_status;
                    else        x_q    <= alu_result;
                    state_q <= S_IDLE;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef ULA_CTRL_RETIRE_CNT_EN
    logic       retire_w;
    logic [7:0] retired_q, retired_d;

    // An instruction retires when it leaves EXEC (load), WB (ALU) or OUT (emit).
    assign retire_w = ((state_q == S_EXEC) && !ir_q[7]) || (state_q == S_WB) ||
                      ((state_q == S_OUT) && out_ready);

    // Saturating increment on each retire.
    always_comb begin
        retired_d = retired_q;
        if (retire_w && (retired_q != 8'hFF)) retired_d = retired_q + 8'd1;
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) retired_q <= '0;
        else     retired_q <= retired_d;
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_ula_ctrl.sv
// Directed self-checking bench for ula_ctrl. It includes a behavioural 4-bit ALU.
module tb_ula_ctrl;
    localparam int DW     = 4;
    localparam int SETTLE = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] alu_x, alu_y, alu_result, out_data;
    logic [2:0]    alu_op;
    logic          alu_status, out_valid, out_ready, flag, busy;
    logic [7:0]    retired;

    int n_chk = 0;
    int n_err = 0;
    int n_out = 0;
    logic [DW-1:0] last_out = '0;

    always #5 clk = ~clk;

    ula_ctrl #(.DATA_W(DW), .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_result(alu_result), .alu_status(alu_status), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .flag(flag), .busy(busy),
        .retired(retired)
    );

    // Reference combinational ALU.
    always_comb begin
        alu_result = '0;
        alu_status = 1'b0;
        case (alu_op)
            3'b000: alu_result = alu_x + alu_y;
            3'b001: alu_result = alu_x - alu_y;
            3'b010: alu_result = DW'(0) - alu_y;
            3'b011: alu_status = (alu_x == alu_y);
            3'b100: alu_status = (alu_x > alu_y);
            3'b101: alu_status = (alu_x < alu_y);
            3'b110: alu_result = alu_x & alu_y;
            default: alu_result = alu_x ^ alu_y;
        endcase
    end

    // Count the completed output transfers.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            n_out    <= n_out + 1;
            last_out <= out_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and return the number of edges from the accept
    // edge through the edge at which instr_ready returns high.
    task automatic issue(input logic [7:0] ins, output int lat);
        int n;
        n = 0;
        instr       = ins;
        instr_valid = 1'b1;
        while (!instr_ready && n < 100) begin tick(); n++; end
        tick();
        instr_valid = 1'b0;
        lat = 1;
        while (!instr_ready && lat < 100) begin tick(); lat++; end
        if (lat >= 100 || n >= 100) chk("timeout", 32'(lat), 32'd0);
    endtask

    int lat;
    int o0;

    initial begin
        rst = 1'b1; instr = '0; instr_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ready", 32'(instr_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_op", 32'(alu_op), 0);
        chk("rst_x", 32'(alu_x), 0);
        chk("rst_y", 32'(alu_y), 0);
        chk("rst_oval", 32'(out_valid), 0);
        chk("rst_odat", 32'(out_data), 0);
        chk("rst_flag", 32'(flag), 0);
        chk("rst_ret", 32'(retired), 0);

        // Basic add followed by an output transfer.
        issue(8'h05, lat); chk("ldx_lat", 32'(lat), 2);
        issue(8'h43, lat);
        chk("ld_x", 32'(alu_x), 5);
        chk("ld_y", 32'(alu_y), 3);
`ifdef ULA_CTRL_RETIRE_CNT_EN
        chk("ret2", 32'(retired), 2);
`else
        chk("ret2", 32'(retired), 0);
`endif
        issue(8'h80, lat); chk("add_lat", 32'(lat), 2 + SETTLE);
        chk("add_x", 32'(alu_x), 8);
        o0 = n_out;
        issue(8'hC0, lat); chk("out_lat", 32'(lat), 3);
        chk("out_cnt", 32'(n_out - o0), 1);
        chk("out_dat", 32'(last_out), 8);
        chk("out_vld0", 32'(out_valid), 0);
        chk("add_flag", 32'(flag), 0);

        // Wrap-around results; instr[5:4] must have no effect.
        issue(8'h03, lat); issue(8'h45, lat);
        issue(8'h81, lat); chk("sub_lat", 32'(lat), 2 + SETTLE);
        chk("sub_wrap", 32'(alu_x), 4'hE);
        issue(8'h40, lat);
        issue(8'h82, lat); chk("neg_lat", 32'(lat), 2 + SETTLE);
        chk("neg0", 32'(alu_x), 0);
        issue(8'h3A, lat); chk("ign54", 32'(alu_x), 4'hA);

        // Compares update the flag and leave X untouched.
        issue(8'h09, lat); issue(8'h44, lat);
        issue(8'h84, lat); chk("gt_flag", 32'(flag), 1); chk("gt_x", 32'(alu_x), 9);
        issue(8'h85, lat); chk("lt_flag", 32'(flag), 0); chk("lt_x", 32'(alu_x), 9);
        issue(8'h49, lat);
        issue(8'h83, lat); chk("eq_flag", 32'(flag), 1);
        issue(8'h87, lat); chk("xor_x", 32'(alu_x), 0); chk("xor_flag", 32'(flag), 1);
        issue(8'h0C, lat); issue(8'h4A, lat);
        issue(8'h86, lat); chk("and_x", 32'(alu_x), 8);

        // Output backpressure.
        issue(8'h07, lat);
        out_ready = 1'b0;
        o0 = n_out;
        instr = 8'hC0; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", 32'(out_valid), 1);
            chk("bp_dat", 32'(out_data), 7);
            chk("bp_rdy", 32'(instr_ready), 0);
            chk("bp_busy", 32'(busy), 1);
            tick();
        end
        chk("bp_none", 32'(n_out - o0), 0);
        out_ready = 1'b1;
        tick();
        chk("bp_done_vld", 32'(out_valid), 0);
        chk("bp_done_rdy", 32'(instr_ready), 1);
        chk("bp_cnt", 32'(n_out - o0), 1);
        chk("bp_last", 32'(last_out), 7);

        // Reset during the WB cycle of an ADD. The flag is still 1 from the eq.
        issue(8'h01, lat); issue(8'h42, lat);
        instr = 8'h80; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        for (int i = 0; i < SETTLE; i++) tick();
        chk("wb_busy", 32'(busy), 1);
        chk("wb_flag_pre", 32'(flag), 1);
        rst = 1'b1; instr = 8'h0F; instr_valid = 1'b1;
        tick();
        chk("rwb_x", 32'(alu_x), 0);
        chk("rwb_y", 32'(alu_y), 0);
        chk("rwb_flag", 32'(flag), 0);
        chk("rwb_ovld", 32'(out_valid), 0);
        chk("rwb_rdy", 32'(instr_ready), 1);
        tick();
        chk("rwb_hold_busy", 32'(busy), 0);
        chk("rwb_hold_x", 32'(alu_x), 0);
        rst = 1'b0;
        tick(); chk("rwb_acc_busy", 32'(busy), 1);
        instr_valid = 1'b0;
        tick(); chk("rwb_acc_x", 32'(alu_x), 4'hF);

        // Reset while OUT is stalled.
        issue(8'h05, lat);
        out_ready = 1'b0;
        instr = 8'hC0; instr_valid = 1'b1;
        tick(); instr_valid = 1'b0;
        tick();
        chk("rout_pre", 32'(out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        chk("rout_vld", 32'(out_valid), 0);
        chk("rout_dat", 32'(out_data), 0);
        chk("rout_rdy", 32'(instr_ready), 1);
        chk("rout_x", 32'(alu_x), 0);

        // Retired counter saturation.
        chk("ret_clr", 32'(retired), 0);
        for (int i = 0; i < 300; i++) issue(8'h01, lat);
`ifdef ULA_CTRL_RETIRE_CNT_EN
        chk("ret_sat", 32'(retired), 255);
`else
        chk("ret_sat", 32'(retired), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
